// File: rtl/sk6812_rx.sv
// SK6812/WS2812 one-wire receiver: measures synchronised high-pulse widths,
// assembles MSB-first GRB words, and reports pixel, latch-gap and framing events.
module sk6812_rx #(
  parameter int unsigned MIN_HIGH       = 2,
  parameter int unsigned BIT_THRESH     = 6,
  parameter int unsigned MAX_HIGH       = 12,
  parameter int unsigned RESET_CYCLES   = 960,
  parameter int unsigned BITS_PER_PIXEL = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      din,
  output logic [BITS_PER_PIXEL-1:0] o_pixel,
  output logic                      o_pixel_dv,
  output logic [7:0]                o_pixel_index,
  output logic                      o_latch,
  output logic                      o_err,
  output logic                      o_busy
);

  localparam int unsigned HW = $clog2(MAX_HIGH + 2);
  localparam int unsigned LW = $clog2(RESET_CYCLES + 1);
  localparam int unsigned BW = $clog2(BITS_PER_PIXEL + 1);

  typedef enum logic [1:0] {S_WAIT_GAP, S_IDLE, S_HIGH, S_LOW} state_t;

  state_t                    r_state, w_state_nx;
  logic                      r_din_meta, r_din_s, r_din_d;
  logic [HW-1:0]             r_high_cnt;
  logic [LW-1:0]             r_low_cnt;
  logic [BW-1:0]             r_bit_cnt;
  logic [BITS_PER_PIXEL-1:0] r_shift;
  logic [7:0]                r_pix_cnt;
  logic                      r_pix_done;

  logic w_rise, w_fall, w_start, w_bit;
  logic w_glitch, w_long, w_accept, w_gap, w_wait_done, w_word_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_din_meta <= 1'b0;
      r_din_s    <= 1'b0;
      r_din_d    <= 1'b0;
    end else begin
      r_din_meta <= din;
      r_din_s    <= r_din_meta;
      r_din_d    <= r_din_s;
    end
  end

  assign w_rise = r_din_s & ~r_din_d;
  assign w_fall = ~r_din_s & r_din_d;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_WAIT_GAP;
    else       r_state <= w_state_nx;
  end

  // A rise landing on the very cycle the gap completes starts a pulse directly,
  // otherwise the first bit after an exact-length gap would be lost.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_WAIT_GAP: if (w_wait_done) w_state_nx = w_rise ? S_HIGH : S_IDLE;
      S_IDLE:     if (w_rise) w_state_nx = S_HIGH;
      S_HIGH:     if (w_fall) w_state_nx = w_long ? S_WAIT_GAP : S_LOW;
      S_LOW: begin
        if (w_rise)     w_state_nx = S_HIGH;
        else if (w_gap) w_state_nx = S_IDLE;
      end
      default:    w_state_nx = S_WAIT_GAP;
    endcase
  end

  always_comb begin
    w_glitch    = 1'b0;
    w_long      = 1'b0;
    w_accept    = 1'b0;
    w_gap       = 1'b0;
    w_wait_done = 1'b0;
    case (r_state)
      S_WAIT_GAP: w_wait_done = (r_low_cnt == LW'(RESET_CYCLES));
      S_HIGH: begin
        if (w_fall) begin
          if (r_high_cnt < HW'(MIN_HIGH))      w_glitch = 1'b1;
          else if (r_high_cnt > HW'(MAX_HIGH)) w_long   = 1'b1;
          else                                 w_accept = 1'b1;
        end
      end
      S_LOW:   w_gap = (r_low_cnt == LW'(RESET_CYCLES));
      default: ;
    endcase
  end

  assign w_start     = w_rise && (r_state == S_IDLE || r_state == S_LOW || w_wait_done);
  assign w_bit       = (r_high_cnt >= HW'(BIT_THRESH));
  assign w_word_done = w_accept && (r_bit_cnt == BW'(BITS_PER_PIXEL - 1));
  assign o_busy      = (r_bit_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_high_cnt    <= '0;
      r_low_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_pix_cnt     <= '0;
      r_pix_done    <= 1'b0;
      o_pixel       <= '0;
      o_pixel_index <= '0;
      o_pixel_dv    <= 1'b0;
      o_latch       <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_pixel_dv <= 1'b0;
      o_latch    <= 1'b0;
      o_err      <= 1'b0;

      if (w_start)
        r_high_cnt <= HW'(1);
      else if (r_state == S_HIGH && !w_fall && r_high_cnt < HW'(MAX_HIGH + 1))
        r_high_cnt <= r_high_cnt + HW'(1);

      case (r_state)
        S_WAIT_GAP: begin
          if (r_din_s)                            r_low_cnt <= '0;
          else if (r_low_cnt < LW'(RESET_CYCLES)) r_low_cnt <= r_low_cnt + LW'(1);
        end
        S_HIGH: if (w_fall) r_low_cnt <= LW'(1);
        S_LOW:  if (r_low_cnt < LW'(RESET_CYCLES)) r_low_cnt <= r_low_cnt + LW'(1);
        default: ;
      endcase

      if (w_long || (w_gap && r_bit_cnt != '0)) begin
        r_bit_cnt <= '0;
        o_err     <= 1'b1;
      end else if (w_accept) begin
        r_shift <= {r_shift[BITS_PER_PIXEL-2:0], w_bit};
        if (w_word_done) begin
          r_bit_cnt     <= '0;
          o_pixel       <= {r_shift[BITS_PER_PIXEL-2:0], w_bit};
          o_pixel_dv    <= 1'b1;
          o_pixel_index <= r_pix_cnt;
          r_pix_cnt     <= r_pix_cnt + 8'd1;
          r_pix_done    <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
        end
      end

      if (w_gap || w_wait_done) begin
        o_latch    <= w_gap && r_pix_done;
        r_pix_cnt  <= '0;
        r_pix_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sk6812_rx.sv
// Scoreboard bench for sk6812_rx: expected pixels are queued as words are sent
// and popped when o_pixel_dv fires; latch/err events are counted and timed.
module tb_sk6812_rx;

  logic        clk = 1'b0;
  logic        reset, din;
  logic [23:0] o_pixel;
  logic        o_pixel_dv;
  logic [7:0]  o_pixel_index;
  logic        o_latch, o_err, o_busy;

  sk6812_rx #(
    .MIN_HIGH      (2),
    .BIT_THRESH    (6),
    .MAX_HIGH      (12),
    .RESET_CYCLES  (960),
    .BITS_PER_PIXEL(24)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .o_pixel      (o_pixel),
    .o_pixel_dv   (o_pixel_dv),
    .o_pixel_index(o_pixel_index),
    .o_latch      (o_latch),
    .o_err        (o_err),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] px;
    logic [7:0]  idx;
    bit          chk;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   vectors = 0, miscompares = 0;
  int   n_dv = 0, n_latch = 0, n_err = 0;
  int   dv_cyc = 0, latch_cyc = 0, err_cyc = 0, t_fall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_pixel_dv === 1'b1) begin
      n_dv++;
      dv_cyc = cyc;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_dv: got pixel=%h idx=%0d, expected no strobe", o_pixel, o_pixel_index);
      end else begin
        e = sb.pop_front();
        if (o_pixel !== e.px || (e.chk && o_pixel_index !== e.idx)) begin
          miscompares++;
          $display("FAIL pixel: got %h idx %0d, expected %h idx %0d", o_pixel, o_pixel_index, e.px, e.idx);
        end
      end
    end
    if (o_latch === 1'b1) begin
      n_latch++;
      latch_cyc = cyc;
    end
    if (o_err === 1'b1) begin
      n_err++;
      err_cyc = cyc;
      vectors++;
      if (o_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL err_busy: o_busy=%b on err strobe, expected 0", o_busy);
      end
    end
  end

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      din = v;
      @(negedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    drive(1'b1, b ? 7 : 4);
    t_fall = cyc;
    drive(1'b0, b ? 8 : 11);
  endtask

  task automatic send_range(input logic [23:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [23:0] w, input logic [7:0] idx, input bit chk, input bit expect_dv);
    if (expect_dv) sb.push_back('{w, idx, chk});
    send_range(w, 23, 0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b1, 3);
    vectors++;
    if ({o_pixel, o_pixel_index, o_pixel_dv, o_latch, o_err, o_busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: px=%h idx=%0d dv=%b l=%b e=%b b=%b, expected all 0",
               o_pixel, o_pixel_index, o_pixel_dv, o_latch, o_err, o_busy);
    end
    reset = 1'b0;
    drive(1'b1, 100);
    drive(1'b0, 960);
    vectors++;
    if (n_dv != 0 || n_latch != 0 || n_err != 0) begin
      miscompares++;
      $display("FAIL pre_gap_strobes: dv=%0d latch=%0d err=%0d, expected 0/0/0", n_dv, n_latch, n_err);
    end
  endtask

  task automatic test_first_pixel;
    send_word(24'hFF0000, 8'd0, 1'b1, 1'b1);
    vectors++;
    if (n_dv != 1) begin
      miscompares++;
      $display("FAIL first_dv_count: got %0d, expected 1", n_dv);
    end
    vectors++;
    if (dv_cyc - t_fall != 3) begin
      miscompares++;
      $display("FAIL dv_latency: got %0d, expected 3", dv_cyc - t_fall);
    end
    drive(1'b0, 1000);
    vectors++;
    if (n_latch != 1) begin
      miscompares++;
      $display("FAIL first_latch: got %0d, expected 1", n_latch);
    end
  endtask

  task automatic test_frame;
    int l0, d0;
    l0 = n_latch;
    d0 = n_dv;
    send_word(24'h123456, 8'd0, 1'b1, 1'b1);
    send_word(24'hA5A5A5, 8'd1, 1'b1, 1'b1);
    send_word(24'h000001, 8'd2, 1'b1, 1'b1);
    drive(1'b0, 1000);
    vectors++;
    if (n_dv != d0 + 3 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL frame_dv: got %0d strobes (%0d pending), expected 3 (0)", n_dv - d0, sb.size());
    end
    vectors++;
    if (n_latch != l0 + 1) begin
      miscompares++;
      $display("FAIL frame_latch_count: got %0d, expected 1", n_latch - l0);
    end
    vectors++;
    if (latch_cyc - t_fall != 963) begin
      miscompares++;
      $display("FAIL latch_latency: got %0d, expected 963", latch_cyc - t_fall);
    end
  endtask

  task automatic test_glitch;
    int e0;
    e0 = n_err;
    sb.push_back('{24'h00FF00, 8'd0, 1'b1});
    send_range(24'h00FF00, 23, 13);
    drive(1'b1, 1);
    drive(1'b0, 6);
    send_range(24'h00FF00, 12, 0);
    vectors++;
    if (n_err != e0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL glitch: err=%0d pending=%0d, expected 0 and 0", n_err - e0, sb.size());
    end
    drive(1'b0, 1000);
  endtask

  task automatic test_framing_err;
    int e0, l0, d0;
    e0 = n_err;
    l0 = n_latch;
    d0 = n_dv;
    send_range(24'hABCDEF, 23, 12);
    drive(1'b1, 20);
    drive(1'b0, 20);
    vectors++;
    if (n_err != e0 + 1 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL long_high: err=%0d busy=%b, expected 1 and 0", n_err - e0, o_busy);
    end
    send_word(24'h123123, 8'd0, 1'b0, 1'b0);
    drive(1'b0, 1000);
    vectors++;
    if (n_dv != d0 || n_latch != l0) begin
      miscompares++;
      $display("FAIL wait_gap_ignore: dv=%0d latch=%0d, expected 0 and 0", n_dv - d0, n_latch - l0);
    end
    send_word(24'hC3C3C3, 8'd0, 1'b0, 1'b1);
    drive(1'b0, 1000);
    vectors++;
    if (n_dv != d0 + 1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL recover_dv: got %0d, expected 1", n_dv - d0);
    end
  endtask

  task automatic test_partial_gap;
    int e0, l0;
    e0 = n_err;
    l0 = n_latch;
    send_range(24'h5AFFFF, 23, 16);
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_partial: got %b, expected 1", o_busy);
    end
    drive(1'b0, 1000);
    vectors++;
    if (n_err != e0 + 1 || n_latch != l0) begin
      miscompares++;
      $display("FAIL partial_gap: err=%0d latch=%0d, expected 1 and 0", n_err - e0, n_latch - l0);
    end
    send_word(24'h0F0F0F, 8'd0, 1'b1, 1'b1);
    send_range(24'h3CFFFF, 23, 16);
    drive(1'b0, 1000);
    vectors++;
    if (n_err != e0 + 2 || n_latch != l0 + 1 || err_cyc != latch_cyc) begin
      miscompares++;
      $display("FAIL err_and_latch: err=%0d latch=%0d err_cyc=%0d latch_cyc=%0d, expected 2 1 equal",
               n_err - e0, n_latch - l0, err_cyc, latch_cyc);
    end
  endtask

  task automatic test_reset_mid_word;
    int l0, d0;
    l0 = n_latch;
    d0 = n_dv;
    send_range(24'h777777, 23, 9);
    reset = 1'b1;
    din   = 1'b0;
    @(negedge clk);
    vectors++;
    if ({o_pixel, o_pixel_index, o_pixel_dv, o_latch, o_err, o_busy} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: px=%h idx=%0d dv=%b l=%b e=%b b=%b, expected all 0",
               o_pixel, o_pixel_index, o_pixel_dv, o_latch, o_err, o_busy);
    end
    reset = 1'b0;
    send_word(24'h111111, 8'd0, 1'b0, 1'b0);
    drive(1'b0, 1000);
    vectors++;
    if (n_latch != l0 || n_dv != d0) begin
      miscompares++;
      $display("FAIL post_reset_ignore: latch=%0d dv=%0d, expected 0 and 0", n_latch - l0, n_dv - d0);
    end
    send_word(24'h5A5A5A, 8'd0, 1'b1, 1'b1);
    drive(1'b0, 20);
    vectors++;
    if (n_dv != d0 + 1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL post_reset_decode: dv=%0d pending=%0d, expected 1 and 0", n_dv - d0, sb.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    din   = 1'b1;
    @(negedge clk);
    test_reset;
    test_first_pixel;
    test_frame;
    test_glitch;
    test_framing_err;
    test_partial_gap;
    test_reset_mid_word;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: bench exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
